// File: rtl/read_pattern_checker.sv
// Read-back pattern checker: compares a stream of read beats against SEED ^ index
// and reports pass/fail, error statistics, the first mismatch and a watchdog timeout.
module read_pattern_checker #(
    parameter int                    DATA_WIDTH    = 64,
    parameter int                    COUNT_WIDTH   = 24,
    parameter logic [DATA_WIDTH-1:0] SEED          = DATA_WIDTH'(64'hdeadfadebabebeef),
    parameter bit                    STOP_ON_ERROR = 1'b1,
    parameter int                    TIMEOUT_WIDTH = 20,
    parameter int                    ERR_WIDTH     = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   avl_rdata_valid,
    input  logic [DATA_WIDTH-1:0]  avl_rdata,
    input  logic                   ddr3_init_done,
    input  logic                   ddr3_cal_success,
    input  logic                   ddr3_cal_fail,
    output logic                   is_finished,
    output logic                   pass,
    output logic                   fail,
    output logic                   timeout,
    output logic [ERR_WIDTH-1:0]   error_count,
    output logic [COUNT_WIDTH:0]   words_checked,
    output logic [COUNT_WIDTH-1:0] first_err_index,
    output logic [DATA_WIDTH-1:0]  first_err_data
);

    typedef enum logic [1:0] {
        WAIT_INIT = 2'd0,
        CHECK     = 2'd1,
        FINISHED  = 2'd2,
        ERROR     = 2'd3
    } state_t;

    state_t                   state_q, state_d;
    logic [COUNT_WIDTH:0]     words_q, words_d;
    logic [ERR_WIDTH-1:0]     err_q, err_d;
    logic [COUNT_WIDTH-1:0]   idx_q, idx_d;
    logic [DATA_WIDTH-1:0]    data_q, data_d;
    logic [TIMEOUT_WIDTH-1:0] idle_q, idle_d;
    logic                     timeout_q, timeout_d;
    logic                     finished_q, finished_d;
    logic                     pass_q, pass_d;
    logic                     fail_q, fail_d;
    logic [DATA_WIDTH-1:0]    expected;

    always_comb begin
        state_d   = state_q;
        words_d   = words_q;
        err_d     = err_q;
        idx_d     = idx_q;
        data_d    = data_q;
        idle_d    = idle_q;
        timeout_d = timeout_q;
        expected  = SEED ^ DATA_WIDTH'(words_q[COUNT_WIDTH-1:0]);

        unique case (state_q)
            WAIT_INIT: begin
                if (ddr3_init_done && ddr3_cal_success) begin
                    state_d = CHECK;
                end else if (ddr3_init_done && ddr3_cal_fail) begin
                    state_d = ERROR;
                end
            end
            CHECK: begin
                // Top bit of the word counter marks that all N beats are in.
                if (words_q[COUNT_WIDTH]) begin
                    state_d = (err_q == '0) ? FINISHED : ERROR;
                end else if (avl_rdata_valid) begin
                    words_d = words_q + (COUNT_WIDTH+1)'(1);
                    idle_d  = '0;
                    if (avl_rdata != expected) begin
                        if (err_q != '1) begin
                            err_d = err_q + ERR_WIDTH'(1);
                        end
                        if (err_q == '0) begin
                            idx_d  = words_q[COUNT_WIDTH-1:0];
                            data_d = avl_rdata;
                        end
                        if (STOP_ON_ERROR) begin
                            state_d = ERROR;
                        end
                    end
                end else begin
                    idle_d = idle_q + TIMEOUT_WIDTH'(1);
                    if (idle_d == '1) begin
                        state_d   = ERROR;
                        timeout_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase

        finished_d = finished_q | (state_d == FINISHED) | (state_d == ERROR);
        pass_d     = pass_q | (state_d == FINISHED);
        fail_d     = fail_q | (state_d == ERROR);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= WAIT_INIT;
            words_q    <= '0;
            err_q      <= '0;
            idx_q      <= '0;
            data_q     <= '0;
            idle_q     <= '0;
            timeout_q  <= 1'b0;
            finished_q <= 1'b0;
            pass_q     <= 1'b0;
            fail_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            words_q    <= words_d;
            err_q      <= err_d;
            idx_q      <= idx_d;
            data_q     <= data_d;
            idle_q     <= idle_d;
            timeout_q  <= timeout_d;
            finished_q <= finished_d;
            pass_q     <= pass_d;
            fail_q     <= fail_d;
        end
    end

    assign is_finished     = finished_q;
    assign pass            = pass_q;
    assign fail            = fail_q;
    assign timeout         = timeout_q;
    assign error_count     = err_q;
    assign words_checked   = words_q;
    assign first_err_index = idx_q;
    assign first_err_data  = data_q;

endmodule

// File: tb/tb_read_pattern_checker.sv
// Directed bench for read_pattern_checker: halting and counting variants
// driven from one shared stimulus stream.
module tb_read_pattern_checker;

    localparam int DW = 64;
    localparam int CW = 4;
    localparam int TW = 6;
    localparam int EW = 16;
    localparam logic [DW-1:0] SEED = 64'hdeadfadebabebeef;

    logic          clk = 1'b0;
    logic          reset;
    logic          valid;
    logic [DW-1:0] rdata;
    logic          init_done, cal_ok, cal_bad;

    logic          fin_h, pass_h, fail_h, to_h;
    logic [EW-1:0] err_h;
    logic [CW:0]   words_h;
    logic [CW-1:0] idx_h;
    logic [DW-1:0] data_h;

    logic          fin_c, pass_c, fail_c, to_c;
    logic [EW-1:0] err_c;
    logic [CW:0]   words_c;
    logic [CW-1:0] idx_c;
    logic [DW-1:0] data_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    read_pattern_checker #(
        .DATA_WIDTH(DW), .COUNT_WIDTH(CW), .SEED(SEED),
        .STOP_ON_ERROR(1'b1), .TIMEOUT_WIDTH(TW), .ERR_WIDTH(EW)
    ) dut_halt (
        .clk(clk), .reset(reset),
        .avl_rdata_valid(valid), .avl_rdata(rdata),
        .ddr3_init_done(init_done), .ddr3_cal_success(cal_ok),
        .ddr3_cal_fail(cal_bad),
        .is_finished(fin_h), .pass(pass_h), .fail(fail_h),
        .timeout(to_h), .error_count(err_h),
        .words_checked(words_h), .first_err_index(idx_h),
        .first_err_data(data_h)
    );

    read_pattern_checker #(
        .DATA_WIDTH(DW), .COUNT_WIDTH(CW), .SEED(SEED),
        .STOP_ON_ERROR(1'b0), .TIMEOUT_WIDTH(TW), .ERR_WIDTH(EW)
    ) dut_cont (
        .clk(clk), .reset(reset),
        .avl_rdata_valid(valid), .avl_rdata(rdata),
        .ddr3_init_done(init_done), .ddr3_cal_success(cal_ok),
        .ddr3_cal_fail(cal_bad),
        .is_finished(fin_c), .pass(pass_c), .fail(fail_c),
        .timeout(to_c), .error_count(err_c),
        .words_checked(words_c), .first_err_index(idx_c),
        .first_err_data(data_c)
    );

    task automatic check(input string tag, input logic [DW-1:0] got,
                         input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        valid     = 1'b0;
        rdata     = '0;
        init_done = 1'b0;
        cal_ok    = 1'b0;
        cal_bad   = 1'b0;
        step();
        reset = 1'b0;
    endtask

    task automatic cal_pass();
        init_done = 1'b1;
        cal_ok    = 1'b1;
        step();
    endtask

    task automatic beat(input logic [DW-1:0] d);
        valid = 1'b1;
        rdata = d;
        step();
        valid = 1'b0;
    endtask

    initial begin
        do_reset();
        check("rst_fin", fin_h, 0);
        check("rst_pass", pass_h, 0);
        check("rst_fail", fail_h, 0);
        check("rst_words", words_h, 0);

        // Beats before the handshake must be ignored.
        beat(SEED);
        check("pre_words", words_h, 0);
        cal_pass();
        for (int i = 0; i < 16; i++) beat(SEED ^ DW'(i));
        check("full_words", words_h, 16);
        check("full_pass_early", pass_h, 0);
        step();
        check("full_pass", pass_h, 1);
        check("full_fail", fail_h, 0);
        check("full_fin", fin_h, 1);
        check("full_err", err_h, 0);
        check("full_pass_c", pass_c, 1);
        beat(SEED ^ DW'(16));
        check("post_words", words_h, 16);

        do_reset();
        init_done = 1'b1;
        cal_bad   = 1'b1;
        step();
        check("calf_fail", fail_h, 1);
        check("calf_fin", fin_h, 1);
        check("calf_pass", pass_h, 0);
        check("calf_words", words_h, 0);

        do_reset();
        cal_pass();
        for (int i = 0; i < 6; i++)
            beat((i == 5) ? (SEED ^ DW'(i) ^ 64'd1) : (SEED ^ DW'(i)));
        check("stop_fail", fail_h, 1);
        check("stop_pass", pass_h, 0);
        check("stop_idx", idx_h, 5);
        check("stop_data", data_h, SEED ^ 64'd5 ^ 64'd1);
        check("stop_err", err_h, 1);
        check("stop_words", words_h, 6);
        check("cont_running", fail_c, 0);
        check("cont_err1", err_c, 1);
        beat(SEED ^ DW'(6));
        check("stop_hold", words_h, 6);

        do_reset();
        cal_pass();
        for (int i = 0; i < 16; i++)
            beat((i == 3 || i == 15) ? (SEED ^ DW'(i) ^ 64'd1)
                                     : (SEED ^ DW'(i)));
        check("cnt_fail_early", fail_c, 0);
        check("cnt_err", err_c, 2);
        step();
        check("cnt_fail", fail_c, 1);
        check("cnt_pass", pass_c, 0);
        check("cnt_idx", idx_c, 3);
        check("cnt_data", data_c, SEED ^ 64'd3 ^ 64'd1);
        check("cnt_words", words_c, 16);

        do_reset();
        cal_pass();
        for (int i = 0; i < 3; i++) beat(SEED ^ DW'(i));
        for (int i = 0; i < 62; i++) step();
        check("to_early", to_h, 0);
        step();
        check("to_flag", to_h, 1);
        check("to_fail", fail_h, 1);
        check("to_words", words_h, 3);
        check("to_pass", pass_h, 0);

        do_reset();
        cal_pass();
        for (int i = 0; i < 8; i++) beat(SEED ^ DW'(i));
        #2;
        reset = 1'b1;
        #1;
        check("arst_words", words_h, 0);
        check("arst_fin", fin_h, 0);
        init_done = 1'b0;
        cal_ok    = 1'b0;
        step();
        reset = 1'b0;
        step();
        check("arst_wait", words_h, 0);
        cal_pass();
        for (int i = 0; i < 16; i++) beat(SEED ^ DW'(i));
        step();
        check("rerun_pass", pass_h, 1);
        check("rerun_fail", fail_h, 0);
        check("rerun_words", words_h, 16);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/read_pattern_checker.md
READ_PATTERN_CHECKER -- requirements
Module: read_pattern_checker

Interface
REQ-001 Parameter DATA_WIDTH, default 64, read data word width; SHALL be >= COUNT_WIDTH+1.
REQ-002 Parameter COUNT_WIDTH, default 24, log2 of words checked per run (N = 2^COUNT_WIDTH).
REQ-003 Parameter SEED, default 64'hdeadfadebabebeef truncated to DATA_WIDTH, pattern base value.
REQ-004 Parameter STOP_ON_ERROR, default 1; 1 = halt on first mismatch, 0 = count and continue.
REQ-005 Parameter TIMEOUT_WIDTH, default 20, width of the idle-cycle watchdog counter.
REQ-006 Parameter ERR_WIDTH, default 16, width of the error counter.
REQ-007 Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high reset
- avl_rdata_valid  in  1  read data beat valid
- avl_rdata  in  DATA_WIDTH  read data beat
- ddr3_init_done  in  1  controller init complete
- ddr3_cal_success  in  1  calibration passed
- ddr3_cal_fail  in  1  calibration failed
- is_finished  out  1  run ended (sticky)
- pass  out  1  run ended, zero errors (sticky)
- fail  out  1  run ended with error, timeout or cal fail (sticky)
- timeout  out  1  watchdog expired (sticky)
- error_count  out  ERR_WIDTH  mismatching beats, saturating
- words_checked  out  COUNT_WIDTH+1  beats consumed
- first_err_index  out  COUNT_WIDTH  index of first mismatch
- first_err_data  out  DATA_WIDTH  data of first mismatch

Function
REQ-008 States: WAIT_INIT, CHECK, FINISHED, ERROR; all outputs registered.
REQ-009 WAIT_INIT: on init_done && cal_success -> CHECK; on init_done && cal_fail && !cal_success -> ERROR; success wins if both high; otherwise hold.
REQ-010 Expected word for index i = SEED XOR zero-extended i (i = words_checked[COUNT_WIDTH-1:0]).
REQ-011 CHECK: each cycle with avl_rdata_valid consumes one beat, compares full DATA_WIDTH, increments words_checked by 1.
REQ-012 avl_rdata_valid outside CHECK is ignored; no counter changes.
REQ-013 Mismatch: error_count increments, saturating at all-ones; if error_count was 0, first_err_index/first_err_data capture i and avl_rdata on same edge.
REQ-014 STOP_ON_ERROR=1: mismatch -> ERROR on same edge; words_checked still increments for that beat.
REQ-015 STOP_ON_ERROR=0: continue in CHECK after mismatch.
REQ-016 When words_checked[COUNT_WIDTH] becomes 1 (N beats consumed), next cycle -> FINISHED if error_count==0, else ERROR; further valid beats ignored.
REQ-017 Last beat mismatch with STOP_ON_ERROR=0: error counted, then ERROR per REQ-016.
REQ-018 Watchdog: in CHECK, idle counter increments each cycle without valid, clears on valid; reaching 2^TIMEOUT_WIDTH-1 -> ERROR with timeout=1 on same edge.
REQ-019 FINISHED: is_finished=1, pass=1 registered on entry edge; terminal until reset.
REQ-020 ERROR: is_finished=1, fail=1 registered on entry edge; terminal until reset.
REQ-021 pass and fail SHALL never both be 1.

Reset
REQ-022 reset high asynchronously forces WAIT_INIT and all outputs, counters and capture registers to 0.
REQ-023 reset mid-run discards all progress; run restarts from index 0 after release and fresh init/cal handshake.

Verification (COUNT_WIDTH=4, TIMEOUT_WIDTH=6, DATA_WIDTH=64 unless stated)
REQ-024 Cal success, 16 correct beats back-to-back -> pass=1, fail=0, error_count=0, words_checked=16.
REQ-025 Cal fail with init_done, no success -> fail=1, is_finished=1 next edge, words_checked=0.
REQ-026 STOP_ON_ERROR=1, beat 5 = expected^1 -> fail=1, first_err_index=5, first_err_data=SEED^5^1, error_count=1, words_checked=6.
REQ-027 STOP_ON_ERROR=0, beats 3 and 15 corrupted -> fail=1 after 16 beats, error_count=2, first_err_index=3.
REQ-028 CHECK, 3 beats then valid low 63 cycles -> timeout=1, fail=1, words_checked=3.
REQ-029 reset asserted after 8 beats -> all outputs 0 asynchronously; rerun of 16 correct beats -> pass=1.
